dmem_responder: RTL and testbench

Data-memory responder serving load/store requests issued by the `pipeline` MEM stage over a valid/ready request and response handshake. It holds one outstanding transaction and inserts a configurable number of wait states. It returns read data or an error flag. It is the memory-side end of the pipeline data-port interface and is instantiated next to `pipeline` in system-level benches.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder slice.
//
// Holds the FSM state encoding, the latched-request record and the width of
// the wait-state counter. ADDR_SIZE normally comes from defines.vh; the guard
// below gives the same 32-bit default when that header is not in the build.
//
// Optional feature macro used by this slice: DMEM_RESP_BYTE_WRITE_EN.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

package dmem_pkg;

  // Width of the wait-state counter; Latency is limited to 0..15.
  localparam int LAT_W = 4;

  // FSM state encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Request captured on acceptance and held until the response handshake.
  typedef struct packed {
    logic                   we;
    logic [`ADDR_SIZE-1:0]  addr;
    logic [31:0]            wdata;
    logic [3:0]             be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- single-port synchronous word memory, Depth x 32.
//
// Ports:
//   clk      rising-edge clock
//   byte_we  per-byte write enables, bit n writes wdata[8n+7:8n]
//   addr     word index
//   wdata    write data
//   rdata    registered read data of the word addressed on the previous edge
//
// The array has no reset, so its contents survive a responder reset.

module dmem_array #(
  parameter int Depth = 256
) (
  input  logic                     clk,
  input  logic [3:0]               byte_we,
  input  logic [$clog2(Depth)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [Depth];

  // Byte-masked write and registered read share the single address port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- memory-side end of the pipeline data port.
//
// Accepts one load/store at a time over a valid/ready request channel,
// waits Latency cycles, then presents a registered response (read data or
// an access-fault flag) over a valid/ready response channel.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_valid_i/ready_o  request handshake
//   req_we_i             1 = store, 0 = load
//   req_addr_i           byte address
//   req_wdata_i          store data
//   req_be_i             byte enables (honoured only with the macro below)
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          load data, 0 for stores and faults
//   rsp_err_o            misaligned or out-of-range access
//
// Macro DMEM_RESP_BYTE_WRITE_EN: when defined, stores write only the bytes
// selected by req_be_i; otherwise every store writes the full word.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AddrSize = `ADDR_SIZE,
  parameter int DataSize = 32,
  parameter int Depth    = 256,
  parameter int Latency  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [AddrSize-1:0] req_addr_i,
  input  logic [DataSize-1:0] req_wdata_i,
  input  logic [3:0]          req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DataSize-1:0] rsp_rdata_o,
  output logic                rsp_err_o
);

  localparam int IdxW = $clog2(Depth);

  logic [1:0]          state;
  logic [LAT_W-1:0]    lat_cnt;
  dmem_req_t           req_q;
  logic                addr_err;
  logic                commit;
  logic [3:0]          wr_mask;
  logic [3:0]          arr_we;
  logic [IdxW-1:0]     arr_addr;
  logic [31:0]         arr_rdata;
  logic [AddrSize-3:0] word_addr;

  // Fault when the address is not word aligned or lies past the last word.
  assign word_addr = req_q.addr[AddrSize-1:2];
  assign addr_err  = (req_q.addr[1:0] != 2'b00) ||
                     (word_addr >= (AddrSize-2)'(Depth));

  // The last WAIT cycle is the one whose closing edge enters RESP.
  assign commit = (state == WAIT) && (lat_cnt == '0);

`ifdef DMEM_RESP_BYTE_WRITE_EN
  assign wr_mask = req_q.be;
`else
  logic be_unused;
  assign be_unused = ^req_q.be;
  assign wr_mask   = 4'hF;
`endif

  assign arr_we = (commit && req_q.we && !addr_err) ? wr_mask : 4'h0;

  // While idle the array already reads the incoming address so that load
  // data is waiting in the read register even when Latency is 0.
  assign arr_addr = (state == IDLE) ? req_addr_i[IdxW+1:2]
                                    : req_q.addr[IdxW+1:2];

  dmem_array #(
    .Depth(Depth)
  ) u_array (
    .clk    (clk_i),
    .byte_we(arr_we),
    .addr   (arr_addr),
    .wdata  (req_q.wdata),
    .rdata  (arr_rdata)
  );

  // Request/response FSM. req_ready_o and all rsp_* outputs are registered
  // alongside the state so no input reaches an output combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      req_q       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_q.we    <= req_we_i;
            req_q.addr  <= req_addr_i;
            req_q.wdata <= req_wdata_i;
            req_q.be    <= req_be_i;
            lat_cnt     <= LAT_W'(Latency);
            req_ready_o <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (commit) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= addr_err;
            rsp_rdata_o <= (!req_q.we && !addr_err) ? arr_rdata : '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder.
//
// Three responders (Latency 0, 2 and 15, Depth 256) share clock and reset.
// Directed vectors, multi-cycle corner cases and a randomized run checked
// against a word-array model of the memory.

module tb_dmem_responder;

  localparam int NDUT = 3;

`ifdef DMEM_RESP_BYTE_WRITE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 15);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .AddrSize(32),
      .DataSize(32),
      .Depth   (256),
      .Latency ((g == 0) ? 0 : ((g == 1) ? 2 : 15))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_we_i   (req_we[g]),
      .req_addr_i (req_addr[g]),
      .req_wdata_i(req_wdata[g]),
      .req_be_i   (req_be[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .rsp_err_o  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high. Called with clk low.
  // edges = number of rising edges after acceptance until rsp_valid is seen.
  task automatic applyStimulus(input int d, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rdata,
                               output logic err, output int edges);
    int guard;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=%0d required=1", req_ready[d]);
      req_valid[d] = 1'b0;
      rdata = 32'hFFFF_FFFF;
      err   = 1'bx;
      edges = -1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    edges = 0;
    while (!rsp_valid[d] && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    if (rsp_valid[d]) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] model [256];
  logic [31:0] byte_exp;
  logic [31:0] be0_exp;

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ed;
    int          guard;

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b1;
    end
    byte_exp = BYTE_EN ? 32'h11BB_33DD : 32'hAABB_CCDD;
    be0_exp  = BYTE_EN ? 32'hDEAD_BEEF : 32'h0BAD_F00D;

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("reset_ready%0d", d), {31'b0, req_ready[d]}, 32'd1);
      checkOutput($sformatf("reset_valid%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
      checkOutput($sformatf("reset_rdata%0d", d), rsp_rdata[d], 32'd0);
      checkOutput($sformatf("reset_err%0d", d), {31'b0, rsp_err[d]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on the Latency = 2 responder.
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, byte_exp, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0022, 32'h0,         4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0013, 32'h1357_9BDF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, be0_exp, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h89AB_CDEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'h89AB_CDEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FE, 32'h0,         4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'h1111_1111, 4'hF, 32'h0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, ed);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_latency", i), ed, 32'd3);
    end

    // Latency 0 and 15 responders: store then load.
    for (int d = 0; d < NDUT; d += 2) begin
      applyStimulus(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, ed);
      checkOutput($sformatf("lat%0d_store_edges", lat_of(d)), ed, lat_of(d) + 1);
      checkOutput($sformatf("lat%0d_store_err", lat_of(d)), {31'b0, er}, 32'd0);
      applyStimulus(d, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, ed);
      checkOutput($sformatf("lat%0d_load_edges", lat_of(d)), ed, lat_of(d) + 1);
      checkOutput($sformatf("lat%0d_load_rdata", lat_of(d)), rd, 32'hDEAD_BEEF);
    end

    // Backpressure: response held for 5 cycles while a new request waits.
    req_we[1] = 1'b0; req_addr[1] = 32'h20; req_be[1] = 4'hF;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    req_addr[1] = 32'h10;
    ed = 0;
    while (!rsp_valid[1] && ed < 40) begin
      @(posedge clk);
      #1;
      ed++;
    end
    checkOutput("bp_first_edges", ed, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid_c%0d", c), {31'b0, rsp_valid[1]}, 32'd1);
      checkOutput($sformatf("bp_rdata_c%0d", c), rsp_rdata[1], byte_exp);
      checkOutput($sformatf("bp_ready_c%0d", c), {31'b0, req_ready[1]}, 32'd0);
    end
    @(negedge clk);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_after_hs_valid", {31'b0, rsp_valid[1]}, 32'd0);
    checkOutput("bp_after_hs_rdata", rsp_rdata[1], 32'd0);
    checkOutput("bp_after_hs_ready", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    ed = 0;
    while (!rsp_valid[1] && ed < 40) begin
      @(posedge clk);
      #1;
      ed++;
    end
    checkOutput("bp_second_edges", ed, 32'd3);
    checkOutput("bp_second_rdata", rsp_rdata[1], be0_exp);
    @(posedge clk);
    @(negedge clk);

    // Reset in WAIT with another request pending: uncommitted store is lost.
    req_we[1] = 1'b1; req_addr[1] = 32'h8; req_wdata[1] = 32'h1234_5678;
    req_be[1] = 4'hF; req_valid[1] = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_wait_ready", {31'b0, req_ready[1]}, 32'd1);
    checkOutput("rst_wait_valid", {31'b0, rsp_valid[1]}, 32'd0);
    checkOutput("rst_wait_rdata", rsp_rdata[1], 32'd0);
    checkOutput("rst_wait_err", {31'b0, rsp_err[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, ed);
    checkOutput("rst_wait_load8", rd, 32'h1111_1111);

    // Reset in RESP after a committed store: the store persists.
    req_we[1] = 1'b1; req_addr[1] = 32'h8; req_wdata[1] = 32'h7777_7777;
    req_be[1] = 4'hF; req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    guard = 0;
    while (!rsp_valid[1] && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("rst_resp_reached", {31'b0, rsp_valid[1]}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_resp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    checkOutput("rst_resp_ready", {31'b0, req_ready[1]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, ed);
    checkOutput("rst_resp_load8", rd, 32'h7777_7777);

    // Randomized run over words 64..79 against a word-array model.
    for (int w = 64; w < 80; w++) begin
      model[w] = $urandom;
      applyStimulus(1, 1'b1, 32'(w * 4), model[w], 4'hF, rd, er, ed);
      checkOutput($sformatf("rnd_init%0d_err", w), {31'b0, er}, 32'd0);
    end
    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_err;
      logic [31:0] exp_rd;
      kind  = $urandom_range(0, 9);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      addr  = 32'(256 + 4 * $urandom_range(0, 15));
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 1) addr = 32'h400 + 32'(4 * $urandom_range(0, 1000));
      exp_err = (addr % 4 != 0) || (addr / 4 >= 256);
      exp_rd  = 32'h0;
      if (!exp_err) begin
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b] || !BYTE_EN) model[addr / 4][8*b +: 8] = wdata[8*b +: 8];
          end
        end else begin
          exp_rd = model[addr / 4];
        end
      end
      applyStimulus(1, we, addr, wdata, be, rd, er, ed);
      checkOutput($sformatf("rnd%0d_rdata_a%h", i, addr), rd, exp_rd);
      checkOutput($sformatf("rnd%0d_err_a%h", i, addr), {31'b0, er}, {31'b0, exp_err});
      checkOutput($sformatf("rnd%0d_latency", i), ed, 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
